// File: rtl/bus_decoder_if.sv
// CPU-side valid/ready port and shared slave-side request/response bundle for bus_decoder.
interface bus_decoder_if #(
    parameter int unsigned N_SLAVES = 2
) ();
    logic                     m_valid;
    logic [31:0]              m_addr;
    logic [31:0]              m_wdata;
    logic [3:0]               m_wstrb;
    logic                     m_ready;
    logic [31:0]              m_rdata;
    logic                     m_err;

    logic [N_SLAVES-1:0]      s_valid;
    logic [31:0]              s_addr;
    logic [31:0]              s_wdata;
    logic [3:0]               s_wstrb;
    logic [N_SLAVES-1:0]      s_ready;
    logic [32*N_SLAVES-1:0]   s_rdata;

    // Environment view: drives CPU requests and slave responses.
    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata, m_err,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

    // Decoder view.
    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata, m_err,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );
endinterface

// File: rtl/bus_decoder.sv
// Single-master address decoder and response router: decodes top address bits to one
// slave, waits for its completion (or a timeout) and returns a registered response.
module bus_decoder #(
    parameter int unsigned                      N_SLAVES    = 2,
    parameter int unsigned                      REGION_BITS = 4,
    parameter logic [N_SLAVES*REGION_BITS-1:0]  REGION_IDS  = 8'h40,
    parameter int unsigned                      TIMEOUT     = 255,
    parameter logic [31:0]                      ERR_DATA    = 32'hDEADBEEF
) (
    input  logic         clk,
    input  logic         resetn,
    bus_decoder_if.slave bus,
    output logic [31:0]  err_addr,
    output logic [7:0]   err_count
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [N_SLAVES-1:0] s_valid_q, s_valid_d;
    logic [31:0]         s_addr_q, s_addr_d;
    logic [31:0]         s_wdata_q, s_wdata_d;
    logic [3:0]          s_wstrb_q, s_wstrb_d;
    logic                m_ready_q, m_ready_d;
    logic                m_err_q, m_err_d;
    logic [31:0]         m_rdata_q, m_rdata_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic [7:0]          err_count_q, err_count_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                hit;
    logic [N_SLAVES-1:0] hit_vec;
    logic [31:0]         rdata_sel;
    logic                grant;
    logic [7:0]          err_count_inc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            s_valid_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            m_ready_q   <= 1'b0;
            m_err_q     <= 1'b0;
            m_rdata_q   <= '0;
            err_addr_q  <= '0;
            err_count_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            s_valid_q   <= s_valid_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            m_ready_q   <= m_ready_d;
            m_err_q     <= m_err_d;
            m_rdata_q   <= m_rdata_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        s_valid_d     = s_valid_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_wstrb_d     = s_wstrb_q;
        m_ready_d     = 1'b0;
        m_err_d       = m_err_q;
        m_rdata_d     = m_rdata_q;
        err_addr_d    = err_addr_q;
        err_count_d   = err_count_q;
        cnt_d         = cnt_q;
        hit           = 1'b0;
        hit_vec       = '0;
        rdata_sel     = '0;
        err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

        // First match wins, so overlapping region IDs resolve to the lowest index.
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (!hit && bus.m_addr[31 -: REGION_BITS] == REGION_IDS[i*REGION_BITS +: REGION_BITS]) begin
                hit        = 1'b1;
                hit_vec[i] = 1'b1;
            end
        end

        // s_valid_q is one-hot, so it doubles as the latched slave index.
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (s_valid_q[i]) begin
                rdata_sel = bus.s_rdata[32*i +: 32];
            end
        end
        grant = |(s_valid_q & bus.s_ready);

        case (state_q)
            IDLE: begin
                if (bus.m_valid) begin
                    s_addr_d  = bus.m_addr;
                    s_wdata_d = bus.m_wdata;
                    s_wstrb_d = bus.m_wstrb;
                    if (hit) begin
                        s_valid_d = hit_vec;
                        cnt_d     = '0;
                        state_d   = ACCESS;
                    end else begin
                        m_ready_d   = 1'b1;
                        m_err_d     = 1'b1;
                        m_rdata_d   = ERR_DATA;
                        err_addr_d  = bus.m_addr;
                        err_count_d = err_count_inc;
                        state_d     = RESP;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (grant) begin
                    s_valid_d = '0;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b0;
                    m_rdata_d = rdata_sel;
                    state_d   = RESP;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    s_valid_d   = '0;
                    m_ready_d   = 1'b1;
                    m_err_d     = 1'b1;
                    m_rdata_d   = ERR_DATA;
                    err_addr_d  = s_addr_q;
                    err_count_d = err_count_inc;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                s_valid_d = '0;
            end
        endcase
    end

    assign bus.s_valid = s_valid_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wstrb = s_wstrb_q;
    assign bus.m_ready = m_ready_q;
    assign bus.m_err   = m_err_q;
    assign bus.m_rdata = m_rdata_q;
    assign err_addr    = err_addr_q;
    assign err_count   = err_count_q;

endmodule
